fifo_addr_gen: RTL

- Upstream address generator for the FIFO load unit's single-entry MSHR hub.
- Walks the head pointer of a circular in-memory FIFO and emits one element address per handshake.
- Stalls while the FIFO is empty, i.e. while the head pointer equals the producer's tail pointer.
- The downstream MSHR hub consumes {valid, addr, size} and returns ready.

---
 rtl/fifo_addr_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_addr_gen.sv
// rtl/fifo_addr_gen.sv - head-pointer address generator for a circular in-memory FIFO
module fifo_addr_gen #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [1:0]        cfg_size_i,
  input  logic              stop_i,
  input  logic [LEN_W-1:0]  prod_ptr_i,
  output logic              addr_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        size_o,
  input  logic              addr_ready_i,
  output logic [LEN_W-1:0]  head_ptr_o,
  output logic [LEN_W-1:0]  issued_cnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_size;
  logic [LEN_W-1:0]  r_head;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  logic              w_xfer;
  logic              w_empty;
  logic              w_slot_free;
  logic              w_load;
  logic              w_start;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_head_nxt;

  assign w_xfer      = r_valid && addr_ready_i;
  assign w_empty     = (r_head == prod_ptr_i);
  assign w_slot_free = !r_valid || addr_ready_i;
  assign w_addr      = r_base + (ADDR_W'(r_head) << r_size);
  assign w_head_nxt  = (r_head == r_len - LEN_W'(1)) ? '0 : r_head + LEN_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid_i && cfg_len_i != '0) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_load = w_slot_free && !w_empty && !stop_i;
        // A slot being drained this cycle counts as empty, so stop goes straight to idle
        if (stop_i) w_state_nxt = w_slot_free ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_xfer) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_head  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_base <= cfg_base_i;
        r_len  <= cfg_len_i;
        r_size <= cfg_size_i;
        r_head <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_xfer) r_cnt <= r_cnt + LEN_W'(1);
        if (w_load) begin
          r_addr <= w_addr;
          r_head <= w_head_nxt;
        end
      end
      if (w_load)      r_valid <= 1'b1;
      else if (w_xfer) r_valid <= 1'b0;
    end
  end

  assign addr_valid_o = r_valid;
  assign addr_o       = r_addr;
  assign size_o       = r_size;
  assign head_ptr_o   = r_head;
  assign issued_cnt_o = r_cnt;
  assign busy_o       = (r_state != S_IDLE);

endmodule
